pinmux_ctrl: RTL and testbench

Parametrised, run-time-configurable pin multiplexer between the sonata peripheral blocks (UART, SPI, I2C, GPIO, PWM) and the board-level input/output pins. It succeeds the fixed, compile-time pin map with per-pin selector registers written over a small register bus. Each output pin has a blanking interlock so no pin glitches between two live sources. Input pins are synchronised before they are routed to block inputs.

---
 rtl/pinmux_ctrl.sv | 152 +++++++++++++++
 tb/tb_pinmux_ctrl.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pinmux_ctrl.sv
// pinmux_ctrl: run-time pin multiplexer with a blanking interlock
// on output pins and synchronised input routing.
module pinmux_ctrl #(
  parameter int unsigned OutPinNum  = 20,
  parameter int unsigned SrcNum     = 4,
  parameter int unsigned InPinNum   = 8,
  parameter int unsigned BlkInNum   = 8,
  parameter int unsigned HoldCycles = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [OutPinNum*SrcNum-1:0] blk_out_i,
  input  logic [OutPinNum*SrcNum-1:0] blk_oe_i,
  output logic [OutPinNum-1:0]        pin_out_o,
  output logic [OutPinNum-1:0]        pin_oe_o,
  input  logic [InPinNum-1:0]         pin_in_i,
  output logic [BlkInNum-1:0]         blk_in_o,
  input  logic                        reg_req_i,
  input  logic                        reg_we_i,
  input  logic [7:0]                  reg_addr_i,
  input  logic [7:0]                  reg_wdata_i,
  output logic [7:0]                  reg_rdata_o,
  output logic                        reg_rvalid_o,
  output logic                        reg_err_o
);
  localparam int unsigned OSW = $clog2(SrcNum + 1);
  localparam int unsigned ISW = $clog2(InPinNum + 1);
  localparam logic [7:0] InBase = 8'h80;
  localparam logic [7:0] Hold = 8'(HoldCycles);

  logic [OutPinNum-1:0][OSW-1:0] tgt_q;
  logic [OutPinNum-1:0][OSW-1:0] act_q;
  logic [OutPinNum-1:0][7:0]     cnt_q;
  logic [BlkInNum-1:0][ISW-1:0]  isel_q;
  logic [InPinNum-1:0]           sync1_q;
  logic [InPinNum-1:0]           sync2_q;

  logic                 out_hit;
  logic                 in_hit;
  logic                 wr_ok;
  logic                 err_d;
  logic [7:0]           rdata_d;
  logic [7:0]           in_off;
  logic [OutPinNum-1:0] out_we;
  logic [BlkInNum-1:0]  in_we;
  logic [OutPinNum-1:0] pin_out_d;
  logic [OutPinNum-1:0] pin_oe_d;
  logic [OSW-1:0]       wsel_o;
  logic [ISW-1:0]       wsel_i;

  assign wsel_o = reg_wdata_i[OSW-1:0];
  assign wsel_i = reg_wdata_i[ISW-1:0];

  always_comb begin
    in_off  = reg_addr_i - InBase;
    out_hit = {24'd0, reg_addr_i} < OutPinNum;
    in_hit  = (reg_addr_i >= InBase) &&
              ({24'd0, in_off} < BlkInNum);
    err_d   = 1'b0;
    rdata_d = '0;
    unique case (1'b1)
      out_hit: begin
        if (reg_we_i) begin
          err_d = {24'd0, reg_wdata_i} > SrcNum;
        end else begin
          for (int p = 0; p < OutPinNum; p++)
            if (reg_addr_i == 8'(p))
              rdata_d = 8'(tgt_q[p]);
        end
      end
      in_hit: begin
        if (reg_we_i) begin
          err_d = {24'd0, reg_wdata_i} > InPinNum;
        end else begin
          for (int k = 0; k < BlkInNum; k++)
            if (in_off == 8'(k))
              rdata_d = 8'(isel_q[k]);
        end
      end
      default: err_d = 1'b1;
    endcase
    wr_ok = reg_req_i && reg_we_i && !err_d;
    for (int p = 0; p < OutPinNum; p++)
      out_we[p] = wr_ok && out_hit && (reg_addr_i == 8'(p));
    for (int k = 0; k < BlkInNum; k++)
      in_we[k] = wr_ok && in_hit && (in_off == 8'(k));
  end

  always_comb begin
    pin_out_d = '0;
    pin_oe_d  = '0;
    for (int p = 0; p < OutPinNum; p++)
      for (int s = 1; s <= SrcNum; s++)
        if (int'(act_q[p]) == s) begin
          pin_out_d[p] = blk_out_i[p*SrcNum+s-1];
          pin_oe_d[p]  = blk_oe_i[p*SrcNum+s-1];
        end
  end

  always_comb begin
    blk_in_o = '1;
    for (int k = 0; k < BlkInNum; k++)
      for (int i = 0; i < InPinNum; i++)
        if (int'(isel_q[k]) == i + 1)
          blk_in_o[k] = sync2_q[i];
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      tgt_q        <= '0;
      act_q        <= '0;
      cnt_q        <= '0;
      isel_q       <= '0;
      sync1_q      <= '1;
      sync2_q      <= '1;
      pin_out_o    <= '0;
      pin_oe_o     <= '0;
      reg_rvalid_o <= 1'b0;
      reg_rdata_o  <= '0;
      reg_err_o    <= 1'b0;
    end else begin
      // A new source is only connected after the pin has been dark
      for (int p = 0; p < OutPinNum; p++) begin
        if (out_we[p] && (wsel_o != tgt_q[p])) begin
          tgt_q[p] <= wsel_o;
          if (wsel_o == '0 || Hold == 8'd0) begin
            act_q[p] <= wsel_o;
            cnt_q[p] <= '0;
          end else begin
            act_q[p] <= '0;
            cnt_q[p] <= Hold;
          end
        end else if (cnt_q[p] == 8'd1) begin
          act_q[p] <= tgt_q[p];
          cnt_q[p] <= '0;
        end else if (cnt_q[p] != 8'd0) begin
          cnt_q[p] <= cnt_q[p] - 8'd1;
        end
      end
      for (int k = 0; k < BlkInNum; k++)
        if (in_we[k])
          isel_q[k] <= wsel_i;
      sync1_q      <= pin_in_i;
      sync2_q      <= sync1_q;
      pin_out_o    <= pin_out_d;
      pin_oe_o     <= pin_oe_d;
      reg_rvalid_o <= reg_req_i;
      reg_rdata_o  <= reg_req_i ? rdata_d : '0;
      reg_err_o    <= reg_req_i && err_d;
    end
  end
endmodule

// File: tb/tb_pinmux_ctrl.sv
// tb_pinmux_ctrl: directed and random scenarios checked against
// a timeline model of pin switching and input routing.
module tb_pinmux_ctrl;
  localparam int OUT = 20;
  localparam int S   = 4;
  localparam int IN  = 8;
  localparam int BLK = 8;
  localparam int H   = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [OUT*S-1:0] blk_out = '0;
  logic [OUT*S-1:0] blk_oe = '0;
  logic [OUT-1:0] pin_out;
  logic [OUT-1:0] pin_oe;
  logic [IN-1:0] pin_in = '1;
  logic [BLK-1:0] blk_in;
  logic req = 1'b0;
  logic we = 1'b0;
  logic [7:0] addr = '0;
  logic [7:0] wdata = '0;
  logic [7:0] rdata;
  logic rvalid;
  logic err;

  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;
  bit rand_en = 1'b1;

  // Model: a pin shows its target from edge m_live onwards, else 0.
  int m_tgt[OUT];
  int m_live[OUT];
  int m_isel[BLK];
  logic [IN-1:0] m_seen1 = '1;
  logic [IN-1:0] m_seen2 = '1;
  logic [OUT-1:0] exp_out = '0;
  logic [OUT-1:0] exp_oe = '0;
  logic [BLK-1:0] exp_blk_in = '1;
  logic exp_rvalid = 1'b0;
  logic exp_err = 1'b0;
  logic exp_rd = 1'b0;
  logic [7:0] exp_rdata = '0;

  always #5 clk = ~clk;

  pinmux_ctrl #(
    .OutPinNum(OUT), .SrcNum(S), .InPinNum(IN),
    .BlkInNum(BLK), .HoldCycles(H)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .blk_out_i(blk_out), .blk_oe_i(blk_oe),
    .pin_out_o(pin_out), .pin_oe_o(pin_oe),
    .pin_in_i(pin_in), .blk_in_o(blk_in),
    .reg_req_i(req), .reg_we_i(we),
    .reg_addr_i(addr), .reg_wdata_i(wdata),
    .reg_rdata_o(rdata), .reg_rvalid_o(rvalid),
    .reg_err_o(err)
  );

  function automatic logic [OUT*S-1:0] rnd_vec();
    logic [95:0] t;
    t = {$urandom(), $urandom(), $urandom()};
    return t[OUT*S-1:0];
  endfunction

  task automatic tick();
    int a;
    int ai;
    @(posedge clk);
    cyc++;
    if (!rst_n) begin
      for (int p = 0; p < OUT; p++) begin
        m_tgt[p] = 0;
        m_live[p] = 0;
      end
      for (int k = 0; k < BLK; k++) m_isel[k] = 0;
      m_seen1 = '1;
      m_seen2 = '1;
      exp_out = '0;
      exp_oe = '0;
      exp_rvalid = 1'b0;
      exp_err = 1'b0;
      exp_rd = 1'b0;
      exp_rdata = '0;
    end else begin
      for (int p = 0; p < OUT; p++) begin
        a = (cyc - 1 >= m_live[p]) ? m_tgt[p] : 0;
        exp_out[p] = (a == 0) ? 1'b0 : blk_out[p*S+a-1];
        exp_oe[p] = (a == 0) ? 1'b0 : blk_oe[p*S+a-1];
      end
      exp_rvalid = req;
      exp_rd = req && !we;
      exp_err = 1'b0;
      exp_rdata = '0;
      ai = int'(addr);
      if (req) begin
        if (ai < OUT) begin
          if (!we) exp_rdata = 8'(m_tgt[ai]);
          else if (int'(wdata) > S) exp_err = 1'b1;
          else if (int'(wdata) != m_tgt[ai]) begin
            m_tgt[ai] = int'(wdata);
            m_live[ai] = (wdata == 8'd0) ? cyc : cyc + H;
          end
        end else if (ai >= 128 && ai < 128 + BLK) begin
          if (!we) exp_rdata = 8'(m_isel[ai-128]);
          else if (int'(wdata) > IN) exp_err = 1'b1;
          else m_isel[ai-128] = int'(wdata);
        end else begin
          exp_err = 1'b1;
        end
      end
      m_seen2 = m_seen1;
      m_seen1 = pin_in;
    end
    for (int k = 0; k < BLK; k++)
      exp_blk_in[k] = (m_isel[k] == 0) ? 1'b1 : m_seen2[m_isel[k]-1];
    #1;
    req = 1'b0;
    if (rand_en) begin
      blk_out = rnd_vec();
      blk_oe = rnd_vec();
    end
  endtask

  task automatic bus(input logic w, input logic [7:0] a,
                     input logic [7:0] d);
    req = 1'b1;
    we = w;
    addr = a;
    wdata = d;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req = 1'($urandom);
      we = 1'($urandom);
      addr = 8'($urandom);
      wdata = 8'($urandom);
      pin_in = 8'($urandom);
      tick();
      n_checks++;
      if (pin_out !== '0) $display("FAIL rst_out got=%h exp=0", pin_out);
      else n_pass++;
      n_checks++;
      if (pin_oe !== '0) $display("FAIL rst_oe got=%h exp=0", pin_oe);
      else n_pass++;
      n_checks++;
      if (blk_in !== 8'hFF) $display("FAIL rst_blk_in got=%h exp=ff", blk_in);
      else n_pass++;
      n_checks++;
      if (rvalid !== 1'b0) $display("FAIL rst_rvalid got=%b exp=0", rvalid);
      else n_pass++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < OUT + BLK; i++) begin
      bus(1'b0, (i < OUT) ? 8'(i) : 8'(128 + i - OUT), 8'd0);
      n_checks++;
      if (rvalid !== 1'b1 || rdata !== 8'd0 || err !== 1'b0)
        $display("FAIL rst_read a=%0d got v=%b d=%h e=%b exp v=1 d=0 e=0",
                 i, rvalid, rdata, err);
      else n_pass++;
    end
  endtask

  task automatic test_switch();
    rand_en = 1'b0;
    blk_out = '0;
    blk_oe = '0;
    blk_out[13] = 1'b1;
    blk_oe[13] = 1'b1;
    blk_oe[12] = 1'b1;
    bus(1'b1, 8'd3, 8'd2);
    for (int e = 1; e <= 5; e++) begin
      tick();
      n_checks++;
      if (pin_out[3] !== (e == 5))
        $display("FAIL sw_rise E%0d got=%b exp=%b", e, pin_out[3], e == 5);
      else n_pass++;
    end
    bus(1'b1, 8'd3, 8'd1);
    for (int e = 1; e <= 5; e++) begin
      tick();
      n_checks++;
      if (pin_oe[3] !== (e == 5) || pin_out[3] !== 1'b0)
        $display("FAIL sw_change E%0d got oe=%b out=%b exp oe=%b out=0",
                 e, pin_oe[3], pin_out[3], e == 5);
      else n_pass++;
    end
  endtask

  task automatic test_rewrite();
    blk_out = '0;
    blk_oe = '0;
    blk_out[13] = 1'b1;
    blk_out[14] = 1'b1;
    blk_oe[14] = 1'b1;
    bus(1'b1, 8'd3, 8'd2);
    tick();
    bus(1'b1, 8'd3, 8'd3);
    for (int e = 1; e <= 5; e++) begin
      tick();
      n_checks++;
      if (pin_out[3] !== (e == 5) || pin_oe[3] !== (e == 5))
        $display("FAIL rewr_blank E2+%0d got out=%b oe=%b exp=%b",
                 e, pin_out[3], pin_oe[3], e == 5);
      else n_pass++;
    end
    bus(1'b1, 8'd3, 8'd3);
    for (int e = 1; e <= 6; e++) begin
      tick();
      n_checks++;
      if (pin_out[3] !== 1'b1)
        $display("FAIL rewr_same E%0d got=%b exp=1", e, pin_out[3]);
      else n_pass++;
    end
  endtask

  task automatic test_disable();
    blk_out = '0;
    blk_oe = '0;
    blk_out[12] = 1'b1;
    blk_oe[12] = 1'b1;
    bus(1'b1, 8'd3, 8'd1);
    tick();
    bus(1'b1, 8'd3, 8'd0);
    for (int e = 1; e <= 6; e++) begin
      tick();
      n_checks++;
      if (pin_out[3] !== 1'b0 || pin_oe[3] !== 1'b0)
        $display("FAIL dis_dark E%0d got out=%b oe=%b exp=0",
                 e, pin_out[3], pin_oe[3]);
      else n_pass++;
    end
    bus(1'b0, 8'd3, 8'd0);
    n_checks++;
    if (rdata !== 8'd0) $display("FAIL dis_read got=%h exp=0", rdata);
    else n_pass++;
    bus(1'b1, 8'd3, 8'd1);
    for (int e = 1; e <= 5; e++) begin
      tick();
      n_checks++;
      if (pin_out[3] !== (e == 5))
        $display("FAIL dis_restart E%0d got=%b exp=%b", e, pin_out[3], e == 5);
      else n_pass++;
    end
  endtask

  task automatic test_inputs();
    pin_in = '1;
    bus(1'b1, 8'h81, 8'd5);
    tick();
    tick();
    for (int t = 0; t < 4; t++) begin
      pin_in[4] = ~pin_in[4];
      tick();
      n_checks++;
      if (blk_in[1] !== ~pin_in[4])
        $display("FAIL in_hold t=%0d got=%b exp=%b", t, blk_in[1], ~pin_in[4]);
      else n_pass++;
      tick();
      n_checks++;
      if (blk_in[1] !== pin_in[4])
        $display("FAIL in_follow t=%0d got=%b exp=%b", t, blk_in[1], pin_in[4]);
      else n_pass++;
    end
    bus(1'b1, 8'h81, 8'd0);
    for (int t = 0; t < 4; t++) begin
      pin_in[4] = ~pin_in[4];
      tick();
      n_checks++;
      if (blk_in[1] !== 1'b1) $display("FAIL in_tied t=%0d got=%b exp=1", t, blk_in[1]);
      else n_pass++;
    end
  endtask

  task automatic test_errors();
    bus(1'b1, 8'd0, 8'd3);
    n_checks++;
    if (rvalid !== 1'b1 || err !== 1'b0)
      $display("FAIL err_ok got v=%b e=%b exp v=1 e=0", rvalid, err);
    else n_pass++;
    bus(1'b1, 8'h7F, 8'd1);
    n_checks++;
    if (rvalid !== 1'b1 || err !== 1'b1)
      $display("FAIL err_unmapped_wr got v=%b e=%b exp v=1 e=1", rvalid, err);
    else n_pass++;
    bus(1'b1, 8'd0, 8'(S + 1));
    n_checks++;
    if (err !== 1'b1) $display("FAIL err_range got=%b exp=1", err);
    else n_pass++;
    bus(1'b1, 8'h88, 8'd1);
    n_checks++;
    if (err !== 1'b1) $display("FAIL err_in_edge got=%b exp=1", err);
    else n_pass++;
    bus(1'b1, 8'h80, 8'(IN + 1));
    n_checks++;
    if (err !== 1'b1) $display("FAIL err_in_range got=%b exp=1", err);
    else n_pass++;
    bus(1'b0, 8'h7F, 8'd0);
    n_checks++;
    if (rdata !== 8'd0 || err !== 1'b1)
      $display("FAIL err_unmapped_rd got d=%h e=%b exp d=0 e=1", rdata, err);
    else n_pass++;
    bus(1'b0, 8'd0, 8'd0);
    n_checks++;
    if (rdata !== 8'd3 || err !== 1'b0)
      $display("FAIL err_keep got d=%h e=%b exp d=3 e=0", rdata, err);
    else n_pass++;
    bus(1'b0, 8'h80, 8'd0);
    n_checks++;
    if (rdata !== 8'd0) $display("FAIL err_in_keep got=%h exp=0", rdata);
    else n_pass++;
  endtask

  task automatic test_random();
    int r;
    rand_en = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 3) == 0) pin_in = 8'($urandom);
      if ($urandom_range(0, 2) != 0) begin
        req = 1'b1;
        we = ($urandom_range(0, 3) != 0);
        r = $urandom_range(0, 9);
        if (r < 5) addr = 8'($urandom_range(0, 3));
        else if (r == 5) addr = 8'($urandom_range(0, OUT - 1));
        else if (r < 8) addr = 8'($urandom_range(128, 128 + BLK - 1));
        else addr = 8'($urandom);
        wdata = ($urandom_range(0, 7) == 0) ? 8'($urandom)
                                            : 8'($urandom_range(0, 9));
      end
      tick();
      n_checks++;
      if (pin_out !== exp_out || pin_oe !== exp_oe)
        $display("FAIL rnd_pins cyc=%0d got=%h/%h exp=%h/%h",
                 cyc, pin_out, pin_oe, exp_out, exp_oe);
      else n_pass++;
      n_checks++;
      if (blk_in !== exp_blk_in)
        $display("FAIL rnd_blk_in cyc=%0d got=%h exp=%h", cyc, blk_in, exp_blk_in);
      else n_pass++;
      n_checks++;
      if (rvalid !== exp_rvalid || (exp_rvalid && err !== exp_err))
        $display("FAIL rnd_resp cyc=%0d got v=%b e=%b exp v=%b e=%b",
                 cyc, rvalid, err, exp_rvalid, exp_err);
      else n_pass++;
      if (exp_rd) begin
        n_checks++;
        if (rdata !== exp_rdata)
          $display("FAIL rnd_rdata cyc=%0d got=%h exp=%h", cyc, rdata, exp_rdata);
        else n_pass++;
      end
    end
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_switch();
    test_rewrite();
    test_disable();
    test_inputs();
    test_errors();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
